// File: rtl/glyph_column_sequencer.sv
// Character FIFO feeding a 5x7 glyph ROM; streams each glyph column by column
// with trailing blank spacer columns over a valid/ready interface.
module glyph_column_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int GLYPH_COLS  = 5,
  parameter int ROWS        = 7,
  parameter int SPACER_COLS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [7:0]                   char_in,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic [6:0]                   rom_addr,
  input  logic [GLYPH_COLS*ROWS-1:0]   rom_data,
  output logic [ROWS-1:0]              col_data,
  output logic                         col_valid,
  input  logic                         col_ready,
  output logic                         col_last,
  output logic                         busy
);

  localparam int TOTAL_COLS = GLYPH_COLS + SPACER_COLS;
  localparam int IDX_W      = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int GLYPH_W    = GLYPH_COLS * ROWS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [7:0]         head;
  logic               fifo_empty, push, load;
  state_t             state;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [GLYPH_W-1:0] glyph;

  // Column k sits MSB-first in the ROM word; indices past the glyph are spacers.
  function automatic logic [ROWS-1:0] column_of(input logic [GLYPH_W-1:0] g,
                                                input logic [IDX_W-1:0] i);
    logic [ROWS-1:0] c;
    c = '0;
    for (int k = 0; k < GLYPH_COLS; k++)
      if (int'(i) == k) c = g[GLYPH_W-1-ROWS*k -: ROWS];
    return c;
  endfunction

  assign fifo_empty = (count == '0);
  assign char_ready = (count != FULL_CNT);
  assign push       = char_valid && char_ready && !clear;
  assign head       = mem[rd_ptr];
  assign rom_addr   = head[7] ? 7'd0 : head[6:0];
  assign busy       = (state == EMIT) || !fifo_empty;
  assign idx_next   = idx + IDX_W'(1);

  // A new glyph is taken from the head either from idle or straight after the
  // last column is accepted, so consecutive characters stream without a bubble.
  assign load = !clear && !fifo_empty &&
                ((state == IDLE) || (col_valid && col_ready && col_last));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      glyph     <= '0;
      col_valid <= 1'b0;
      col_data  <= '0;
      col_last  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      idx       <= '0;
      col_valid <= 1'b0;
      col_data  <= '0;
      col_last  <= 1'b0;
    end else if (load) begin
      state     <= EMIT;
      glyph     <= rom_data;
      idx       <= '0;
      col_valid <= 1'b1;
      col_data  <= column_of(rom_data, '0);
      col_last  <= (LAST_IDX == '0);
    end else if (state == EMIT && col_ready) begin
      if (!col_last) begin
        idx      <= idx_next;
        col_data <= column_of(glyph, idx_next);
        col_last <= (idx_next == LAST_IDX);
      end else begin
        state     <= IDLE;
        idx       <= '0;
        col_valid <= 1'b0;
        col_data  <= '0;
        col_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glyph_column_sequencer.sv
// Scoreboard bench: accepted characters expand into expected columns in a queue;
// a negedge monitor pops and compares every accepted column.
module tb_glyph_column_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, clear, char_valid, char_ready, col_ready, col_valid, col_last, busy;
  logic [7:0]  char_in;
  logic [6:0]  rom_addr, col_data;
  logic [34:0] rom_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_last_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  glyph_column_sequencer #(.FIFO_DEPTH(4), .GLYPH_COLS(5), .ROWS(7), .SPACER_COLS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
    .col_last(col_last), .busy(busy)
  );

  // Test ROM: codes below 0x20 are blank, otherwise column c holds addr+c.
  function automatic logic [34:0] rom_fn(input logic [6:0] a);
    logic [34:0] w;
    w = '0;
    if (a >= 7'h20)
      for (int c = 0; c < 5; c++) w[34-7*c -: 7] = a + 7'(c);
    return w;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  // What a character should look like on the column stream.
  function automatic logic [6:0] ref_col(input logic [7:0] ch, input int c);
    if (ch[7] || ch < 8'h20 || c >= 5) return 7'h00;
    return ch[6:0] + 7'(c);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (col_valid && col_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL col_unexpected: got %0h with nothing expected at %0t",
                   {col_last, col_data}, $time);
        end else begin
          check("col", {56'd0, col_last, col_data}, {56'd0, exp_q.pop_front()});
        end
        if (col_last) n_last_seen++;
      end
      if (clear) exp_q.delete();
      else if (char_valid && char_ready)
        for (int c = 0; c < 6; c++) begin
          logic l;
          l = (c == 5);
          exp_q.push_back({l, ref_col(char_in, c)});
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 500) begin step(); k++; end
    check({name, "_idle"}, {63'd0, busy}, 64'd0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!col_valid && k < 50) begin step(); k++; end
    check({name, "_valid"}, {63'd0, col_valid}, 64'd1);
  endtask

  task automatic push_char(input logic [7:0] ch);
    char_in = ch;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] hello [4];
    logic [7:0] first;
    logic [63:0] last_mask;
    int nv, first_v, last_v;

    hello = '{8'h48, 8'h45, 8'h4C, 8'h4F};
    rst_n = 1'b0; clear = 1'b0; char_valid = 1'b0; char_in = 8'h00; col_ready = 1'b0;
    #12;
    check("rst_col_valid", {63'd0, col_valid}, 0);
    check("rst_col_data", {57'd0, col_data}, 0);
    check("rst_col_last", {63'd0, col_last}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_char_ready", {63'd0, char_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single glyph and first-column latency
    col_ready = 1'b1;
    push_char(8'h41);
    check("t1_rom_addr", {57'd0, rom_addr}, 64'h41);
    check("t1_not_yet_valid", {63'd0, col_valid}, 0);
    check("t1_busy", {63'd0, busy}, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_valid_%0d", i), {63'd0, col_valid}, 1);
      check($sformatf("t1_last_%0d", i), {63'd0, col_last}, (i == 5) ? 1 : 0);
      step();
    end
    check("t1_valid_after", {63'd0, col_valid}, 0);
    check("t1_busy_after", {63'd0, busy}, 0);

    // Back-to-back "HELO"
    nv = 0; first_v = -1; last_v = -1; last_mask = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 4) begin char_in = hello[cyc]; char_valid = 1'b1; end
      else char_valid = 1'b0;
      if (col_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        nv++;
        if (col_last) last_mask[cyc - first_v] = 1'b1;
      end
      step();
    end
    check("b2b_count", nv, 24);
    check("b2b_span", last_v - first_v + 1, 24);
    check("b2b_last_pos", last_mask, (64'd1 << 5) | (64'd1 << 11) | (64'd1 << 17) | (64'd1 << 23));
    wait_idle("b2b");

    // Backpressure at column 2
    push_char(8'h41);
    wait_valid("bp");
    step();
    step();
    col_ready = 1'b0;
    check("bp_col2", {57'd0, col_data}, {57'd0, ref_col(8'h41, 2)});
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_data_%0d", i), {57'd0, col_data}, {57'd0, ref_col(8'h41, 2)});
      check($sformatf("bp_hold_last_%0d", i), {63'd0, col_last}, 0);
    end
    col_ready = 1'b1;
    wait_idle("bp");

    // FIFO full
    col_ready = 1'b0;
    n_last_seen = 0;
    first = 8'h00;
    for (int i = 0; i < 6; i++) begin
      char_in = 8'($urandom_range(8'h20, 8'h7E));
      if (i == 0) first = char_in;
      char_valid = 1'b1;
      check($sformatf("full_ready_%0d", i), {63'd0, char_ready}, (i == 5) ? 0 : 1);
      step();
    end
    char_valid = 1'b0;
    check("full_ready_after", {63'd0, char_ready}, 0);
    check("full_busy", {63'd0, busy}, 1);
    check("full_first_col", {57'd0, col_data}, {57'd0, ref_col(first, 0)});
    col_ready = 1'b1;
    wait_idle("full");
    check("full_chars_out", n_last_seen, 5);

    // Blank mapping
    col_ready = 1'b0;
    push_char(8'hC1);
    check("blank_hi_addr", {57'd0, rom_addr}, 0);
    push_char(8'h05);
    check("blank_ctl_addr", {57'd0, rom_addr}, 64'h05);
    check("blank_hi_col0", {57'd0, col_data}, 0);
    col_ready = 1'b1;
    wait_idle("blank");

    // Clear at column 3 with two characters queued
    push_char(8'h41); push_char(8'h42); push_char(8'h43);
    step(); step();
    check("clr_col3", {57'd0, col_data}, {57'd0, ref_col(8'h41, 3)});
    col_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_valid", {63'd0, col_valid}, 0);
    check("clr_busy", {63'd0, busy}, 0);
    check("clr_ready", {63'd0, char_ready}, 1);
    col_ready = 1'b1;
    step(); step();
    check("clr_stays_idle", {63'd0, col_valid}, 0);

    // Asynchronous reset mid-glyph
    push_char(8'h41); push_char(8'h42); push_char(8'h43);
    step(); step();
    check("rst2_col3", {57'd0, col_data}, {57'd0, ref_col(8'h41, 3)});
    #2 rst_n = 1'b0;
    #1;
    check("rst2_col_valid", {63'd0, col_valid}, 0);
    check("rst2_col_data", {57'd0, col_data}, 0);
    check("rst2_col_last", {63'd0, col_last}, 0);
    check("rst2_busy", {63'd0, busy}, 0);
    check("rst2_char_ready", {63'd0, char_ready}, 1);
    exp_q.delete();
    rst_n = 1'b1;
    step(); step();
    check("rst2_stays_idle", {63'd0, col_valid}, 0);

    // Randomized traffic with occasional clear
    for (int cyc = 0; cyc < 400; cyc++) begin
      char_valid = ($urandom_range(0, 2) != 0);
      char_in    = 8'($urandom);
      col_ready  = ($urandom_range(0, 9) < 7);
      clear      = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0;
    char_valid = 1'b0;
    col_ready = 1'b1;
    wait_idle("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/glyph_column_sequencer.md
Name: glyph_column_sequencer

Overview:
- Buffers a stream of ASCII character codes and fetches each glyph from the 5x7 character ROM (35-bit word per character).
- Emits each glyph one 7-bit column at a time over a valid/ready stream, followed by blank spacer columns.
- Sits between the peripheral register interface and the LED-matrix pixel formatter that drives the WS2812B serializer.
- Owns the ROM address bus; the ROM is a combinational lookup.

Parameters:
- FIFO_DEPTH, 4, character FIFO entries; power of two, at least 2.
- GLYPH_COLS, 5, columns per glyph taken from the ROM word.
- ROWS, 7, bits per column.
- SPACER_COLS, 1, blank columns appended after each glyph; 0 is legal.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of FIFO and current glyph.
- char_in  in  8  character code.
- char_valid  in  1  char_in valid.
- char_ready  out  1  FIFO can accept.
- rom_addr  out  7  character ROM address.
- rom_data  in  35  character ROM data, combinational from rom_addr.
- col_data  out  7  current column; bit 6 = top row.
- col_valid  out  1  col_data valid.
- col_ready  in  1  downstream accepts column.
- col_last  out  1  marks the final column of this character, spacer included.
- busy  out  1  FIFO non-empty or glyph in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; state IDLE; column index 0; glyph register 0.
  - Outputs: col_valid=0, col_data=0, col_last=0, busy=0, char_ready=1.
- FIFO:
  - Push when char_valid && char_ready.
  - char_ready = !full; no push-through on a simultaneous pop while full.
  - Push and pop in the same cycle leave the count unchanged.
- rom_addr is combinational from the FIFO head:
  - head[7]==0: rom_addr = head[6:0].
  - head[7]==1: rom_addr = 0, so the ROM returns 0 and the glyph is blank.
  - Codes below 0x20 are also blank, via the ROM.
- Glyph bit layout: column c (0..GLYPH_COLS-1) = rom_data[34-7c -: 7]; bit 6 = top row.
- State IDLE:
  - If FIFO is non-empty: latch rom_data into the glyph register, pop the FIFO, set column index 0, go to EMIT, all at the same edge.
  - A character pushed at edge N into an empty FIFO produces col_valid=1 after edge N+1.
- State EMIT:
  - col_valid=1.
  - col_data = glyph column[idx] for idx < GLYPH_COLS, else 0 (spacer).
  - col_last=1 when idx = GLYPH_COLS+SPACER_COLS-1.
  - On col_ready with !col_last: idx += 1.
  - On col_ready with col_last and FIFO non-empty: load the next glyph and pop at the same edge, idx=0, stay in EMIT. There is no bubble between characters.
  - On col_ready with col_last and FIFO empty: go to IDLE; col_valid=0 next cycle.
- Backpressure: while col_valid && !col_ready, col_data, col_last and idx hold stable.
- clear (synchronous):
  - At the edge, FIFO is emptied, state goes to IDLE, idx=0, and col_valid drops.
  - clear has priority over a simultaneous push; that character is dropped.
- Reset mid-glyph: asynchronous return to reset values; a partial glyph is never resumed.
- busy = (state==EMIT) || FIFO non-empty.
- Counters: idx width is clog2(GLYPH_COLS+SPACER_COLS); FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

Test Plan:
- Single glyph:
  - Stimulus: ROM model returns 35'h7_FFFF_FFFF masked per column (column c = 7'h41+c); push 0x41; col_ready=1.
  - Required: rom_addr=0x41 while queued; columns 0x41,0x42,0x43,0x44,0x45,0x00 on consecutive cycles; col_last only on the 6th; col_valid first after edge N+1; busy falls after.
- Back-to-back: push "HELO" (0x48,0x45,0x4C,0x4F) with col_ready=1 -> 24 consecutive col_valid cycles with no gap, col_last on cycles 6/12/18/24.
- Backpressure: hold col_ready=0 for 3 cycles at column 2 -> col_data and col_last stay constant; after release the sequence resumes at column 2 with no column lost or duplicated.
- FIFO full: col_ready=0; push 6 chars on consecutive cycles -> 1 char in the glyph register, 4 in the FIFO; char_ready=0 from the 6th attempt; the 6th char is not accepted.
- Blank mapping: push 0xC1 and 0x05 -> rom_addr=0 and rom_addr=0x05 respectively; each yields 6 zero columns with col_last on the 6th.
- Clear and reset: assert clear during column 3 with 2 chars queued -> next cycle col_valid=0, busy=0, char_ready=1. Repeat with a rst_n pulse mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge.
